// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg -- shared definitions for the multi-port register file.
//   * rf_state_e     : sequencing state (clear sweep / operational)
//   * RF_*_DEF       : default parameter values used by regfile_mp
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_NRD_DEF   = 2;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard -- one busy bit per architectural register.
// A busy bit is set when a producer is issued and cleared when that register
// is written back. When both hit the same register in one cycle, the set wins
// because it belongs to the newer producer.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears every busy bit
//   set_en   in   set busy[set_addr] (caller qualifies with ready / addr!=0)
//   set_addr in   AW      register to mark busy
//   clr_en   in   clear busy[clr_addr]
//   clr_addr in   AW      register to mark available
//   ra       in   NRD*AW  packed lookup addresses
//   rbusy    out  NRD     registered busy bit for each lookup address
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD-1:0]      rbusy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;
    logic [NREGS-1:0] busy_nx_s;

    // One-hot set/clear masks; set is OR-ed in after the clear so it dominates.
    always_comb begin
        set_mask_s = {NREGS{1'b0}};
        clr_mask_s = {NREGS{1'b0}};
        for (int k = 0; k < NREGS; k++) begin
            set_mask_s[k] = set_en && (set_addr == AW'(k));
            clr_mask_s[k] = clr_en && (clr_addr == AW'(k));
        end
        busy_nx_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_nx_s;
        end
    end

    // Per-port lookup of the registered busy bit.
    always_comb begin
        rbusy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rbusy[i] = busy_r[ra[i*AW +: AW]];
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-read-port register file with x0 hardwired to zero and a
// busy-bit scoreboard. After reset, registers 1..NREGS-1 are zeroed one per
// cycle; ready rises once the sweep completes. Writes and scoreboard sets are
// ignored until then and all read ports return zero.
//
// Optional build macro:
//   REGFILE_BYPASS_EN  -- a write in flight is forwarded to any read port with
//                         a matching address in the same cycle (rd = wd and
//                         the forwarded rbusy reflects the post-edge state).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (restarts the clear sweep)
//   ready    out  1 when the clear sweep is done
//   ra       in   NRD*AW   packed read addresses, port i = slice i
//   rd       out  NRD*XLEN packed read data, combinational from ra
//   rbusy    out  NRD      scoreboard busy bit per read address
//   we/wa/wd in   write enable / address / data
//   sb_set   in   mark sb_addr busy
//   sb_addr  in   AW       scoreboard set address
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = RF_NRD_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);

    rf_state_e          state_r;
    rf_state_e          state_nx_s;
    logic [AW-1:0]      cnt_r;
    logic [AW-1:0]      cnt_nx_s;
    logic               ready_r;
    logic               ready_nx_s;
    logic               clr_we_s;
    logic               in_ready_s;
    logic               wr_en_s;
    logic               sb_set_en_s;
    logic               sb_clr_en_s;
    logic [NRD-1:0]     sb_rbusy_s;
    logic [XLEN-1:0]    regs_r [NREGS];

    assign ready      = ready_r;
    assign in_ready_s = (state_r == RF_READY);
    assign wr_en_s    = in_ready_s && we && (wa != {AW{1'b0}});
    // x0 is never marked busy; scoreboard updates are held off during the sweep.
    assign sb_set_en_s = in_ready_s && sb_set && (sb_addr != {AW{1'b0}});
    assign sb_clr_en_s = in_ready_s && we;

    // Sequencer state, sweep index and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RF_CLEAR;
            cnt_r   <= AW'(1);
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            ready_r <= ready_nx_s;
        end
    end

    // Next-state logic: sweep 1..NREGS-1, become ready on the edge that clears the last index.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        ready_nx_s = ready_r;
        clr_we_s   = 1'b0;
        case (state_r)
            RF_CLEAR: begin
                clr_we_s = 1'b1;
                cnt_nx_s = cnt_r + AW'(1);
                if (cnt_r == AW'(NREGS - 1)) begin
                    state_nx_s = RF_READY;
                    ready_nx_s = 1'b1;
                end else begin
                    state_nx_s = RF_CLEAR;
                    ready_nx_s = 1'b0;
                end
            end
            RF_READY: begin
                state_nx_s = RF_READY;
                ready_nx_s = 1'b1;
            end
            default: begin
                state_nx_s = RF_CLEAR;
                cnt_nx_s   = AW'(1);
                ready_nx_s = 1'b0;
            end
        endcase
    end

    // Register storage: no reset, zeroed only by the sweep; x0 is never written.
    always_ff @(posedge clk) begin
        if (!rst && clr_we_s) begin
            regs_r[cnt_r] <= {XLEN{1'b0}};
        end else if (!rst && wr_en_s) begin
            regs_r[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set_en_s),
        .set_addr (sb_addr),
        .clr_en   (sb_clr_en_s),
        .clr_addr (wa),
        .ra       (ra),
        .rbusy    (sb_rbusy_s)
    );

    for (genvar g = 0; g < NRD; g++) begin : g_rport
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] port_rd_s;
        logic            port_busy_s;

        assign addr_s = ra[g*AW +: AW];
        assign rd[g*XLEN +: XLEN] = port_rd_s;
        assign rbusy[g]           = port_busy_s;

        // Read mux: zero during the sweep and for x0, optional write forwarding, else storage.
        always_comb begin
            port_rd_s   = {XLEN{1'b0}};
            port_busy_s = 1'b0;
            if (!in_ready_s) begin
                port_rd_s   = {XLEN{1'b0}};
                port_busy_s = 1'b0;
            end else if (addr_s == {AW{1'b0}}) begin
                port_rd_s   = {XLEN{1'b0}};
                port_busy_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_en_s && (wa == addr_s)) begin
                // The write retires this register; it only stays busy if a new
                // producer claims it on the same edge.
                port_rd_s   = wd;
                port_busy_s = sb_set && (sb_addr == addr_s);
`endif
            end else begin
                port_rd_s   = regs_r[addr_s];
                port_busy_s = sb_rbusy_s[g];
            end
        end
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (XLEN=32, NREGS=32,
// NRD=2). A behavioural model tracks register values, busy flags and the
// number of cycles since reset release; directed steps are followed by a
// randomized phase that includes occasional resets.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic                ready;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    bit              m_ready = 1'b0;
    int              m_rel   = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .ra      (ra),
        .rd      (rd),
        .rbusy   (rbusy),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .sb_set  (sb_set),
        .sb_addr (sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: expected read data for an address given the current inputs.
    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (!m_ready || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 5'd0 && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!m_ready || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 5'd0 && wa == a) return sb_set && (sb_addr == a);
`endif
        return m_busy[a];
    endfunction

    // Model: effect of one rising edge with the current inputs.
    function automatic void model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_rel   = 0;
            for (int k = 0; k < NREGS; k++) m_busy[k] = 1'b0;
        end else if (!m_ready) begin
            m_rel++;
            if (m_rel == NREGS - 1) begin
                m_ready = 1'b1;
                for (int k = 0; k < NREGS; k++) m_regs[k] = 32'd0;
            end
        end else begin
            if (we && wa != 5'd0) m_regs[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
    endtask

    task automatic check_reads();
        #1;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rd%0d@x%0d", i, ra[i*AW +: AW]), rd[i*XLEN +: XLEN], exp_rd(ra[i*AW +: AW]));
            chk($sformatf("rbusy%0d@x%0d", i, ra[i*AW +: AW]), {31'd0, rbusy[i]}, {31'd0, exp_busy(ra[i*AW +: AW])});
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = 5'd0; wd = 32'd0; sb_set = 1'b0; sb_addr = 5'd0;
    endtask

    task automatic sweep_all_zero(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            ra = {a[4:0], a[4:0]};
            #1;
            chk({tag, "_rd"}, rd[31:0], 32'd0);
            chk({tag, "_rbusy"}, {31'd0, rbusy[0]}, 32'd0);
            check_reads();
        end
    endtask

    initial begin
        int lat;
        idle_inputs();
        ra  = 10'd0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        ra = {5'd7, 5'd3};
        check_reads();

        // release reset and measure latency to ready
        rst = 1'b0;
        lat = 0;
        while (!ready && lat < 100) begin
            check_reads();
            tick();
            lat++;
        end
        chk("ready_latency", lat, 32'd31);
        sweep_all_zero("post_clear");

        // write x5, read on both ports at once
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        idle_inputs();
        ra = {5'd5, 5'd5};
        #1;
        chk("x5_port0", rd[31:0], 32'hDEADBEEF);
        chk("x5_port1", rd[63:32], 32'hDEADBEEF);
        check_reads();

        // write to x0 is discarded
        we = 1'b1; wa = 5'd0; wd = 32'h00001234;
        tick();
        idle_inputs();
        ra = {5'd0, 5'd0};
        #1;
        chk("x0_read", rd[31:0], 32'd0);
        check_reads();

        // scoreboard: set x7, write x7 next cycle
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        idle_inputs();
        ra = {5'd5, 5'd7};
        #1;
        chk("x7_busy_set", {31'd0, rbusy[0]}, 32'd1);
        we = 1'b1; wa = 5'd7; wd = 32'h000000A5;
        check_reads();
        tick();
        idle_inputs();
        #1;
        chk("x7_busy_cleared", {31'd0, rbusy[0]}, 32'd0);
        chk("x7_data", rd[31:0], 32'h000000A5);
        // same-cycle set and write: set wins
        sb_set = 1'b1; sb_addr = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h0000005A;
        check_reads();
        tick();
        idle_inputs();
        #1;
        chk("x7_busy_setwins", {31'd0, rbusy[0]}, 32'd1);
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        idle_inputs();
        #1;
        chk("x7_busy_reset_again", {31'd0, rbusy[0]}, 32'd1);

        // read-during-write on x3
        ra = {5'd0, 5'd3};
        we = 1'b1; wa = 5'd3; wd = 32'h00000055;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x3_same_cycle", rd[31:0], 32'h00000055);
`else
        chk("x3_same_cycle", rd[31:0], 32'h00000000);
`endif
        check_reads();
        tick();
        idle_inputs();
        #1;
        chk("x3_after_edge", rd[31:0], 32'h00000055);

        // reset while ready with x9 written and busy
        we = 1'b1; wa = 5'd9; wd = 32'h000000FF;
        tick();
        idle_inputs();
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle_inputs();
        ra = {5'd9, 5'd9};
        #1;
        chk("x9_before_rst", rd[31:0], 32'h000000FF);
        chk("x9_busy_before_rst", {31'd0, rbusy[0]}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready_low", {31'd0, ready}, 32'd0);
        chk("rst_busy_low", {31'd0, rbusy[0]}, 32'd0);
        chk("rst_rd_low", rd[31:0], 32'd0);

        // writes and scoreboard sets during the sweep are ignored
        lat = 0;
        while (!ready && lat < 100) begin
            we = 1'b1; wa = 5'($urandom_range(1, 31)); wd = $urandom;
            sb_set = 1'b1; sb_addr = 5'($urandom_range(1, 31));
            check_reads();
            tick();
            lat++;
        end
        idle_inputs();
        chk("rerun_latency", lat, 32'd31);
        sweep_all_zero("after_rst");

        // randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 79) == 0);
            we     = $urandom_range(0, 1) == 1;
            wa     = 5'($urandom_range(0, 31));
            wd     = $urandom;
            sb_set = $urandom_range(0, 2) == 0;
            sb_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra[4:0] = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
            ra[9:5] = ($urandom_range(0, 3) == 0) ? ra[4:0] : 5'($urandom_range(0, 31));
            check_reads();
            tick();
        end
        rst = 1'b0;
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_regfile_mp
